// File: rtl/interval_timer_sequencer.sv
// Interval timer and four-entry timing table for the traffic light controller.
// A single countdown runs at one tick per CLK_DIV clocks and reports completion with a one-cycle expired pulse.
module interval_timer_sequencer #(
    parameter int CLK_DIV  = 4,
    parameter int DEF_BASE = 6,
    parameter int DEF_EXT  = 3,
    parameter int DEF_YEL  = 2,
    parameter int DEF_WALK = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       reprogram,
    input  logic [1:0] extTimeSelector,
    input  logic [3:0] extTimeValue,
    input  logic       start,
    input  logic [1:0] interval,
    output logic [3:0] tv,
    output logic       en,
    output logic [3:0] count,
    output logic       busy,
    output logic       expired,
    output logic       reprog_ack
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [DIV_W-1:0] div;
    logic [3:0]       tbl [4];

    // A zero interval would never expire, so it is promoted to one tick.
    function automatic logic [3:0] clamp_min1(input logic [3:0] v);
        return (v == 4'd0) ? 4'd1 : v;
    endfunction

    assign tv   = tbl[interval];
    assign busy = (state == RUN);
    assign en   = (state == RUN) && (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            tbl[0]     <= 4'(DEF_BASE);
            tbl[1]     <= 4'(DEF_EXT);
            tbl[2]     <= 4'(DEF_YEL);
            tbl[3]     <= 4'(DEF_WALK);
            state      <= IDLE;
            div        <= '0;
            count      <= 4'd0;
            expired    <= 1'b0;
            reprog_ack <= 1'b0;
        end else begin
            expired    <= 1'b0;
            reprog_ack <= 1'b0;
            if (reprogram) begin
                // A table write always cancels any countdown in flight.
                tbl[extTimeSelector] <= clamp_min1(extTimeValue);
                reprog_ack           <= 1'b1;
                state                <= IDLE;
                div                  <= '0;
                count                <= 4'd0;
            end else if (start) begin
                count <= tbl[interval];
                div   <= '0;
                state <= RUN;
            end else if (state == RUN) begin
                div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
                if (en) begin
                    if (count == 4'd1) begin
                        count   <= 4'd0;
                        state   <= IDLE;
                        expired <= 1'b1;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
            end else begin
                div <= '0;
            end
        end
    end

endmodule

// File: tb/tb_interval_timer_sequencer.sv
// Self-checking bench for interval_timer_sequencer: table vectors for reprogramming
// plus a scoreboard of expected expiry cycles for the countdown scenarios.
module tb_interval_timer_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       reprogram;
    logic [1:0] extTimeSelector;
    logic [3:0] extTimeValue;
    logic       start;
    logic [1:0] interval;
    logic [3:0] tv;
    logic       en;
    logic [3:0] count;
    logic       busy;
    logic       expired;
    logic       reprog_ack;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int q[$];

    typedef struct {
        logic       rp;
        logic [1:0] sel;
        logic [3:0] val;
        logic [1:0] iv;
        logic [3:0] exp_tv;
        logic       exp_ack;
    } vec_t;

    vec_t vecs[9];

    interval_timer_sequencer #(
        .CLK_DIV(4), .DEF_BASE(6), .DEF_EXT(3), .DEF_YEL(2), .DEF_WALK(3)
    ) dut (
        .clk(clk), .reset(reset), .reprogram(reprogram),
        .extTimeSelector(extTimeSelector), .extTimeValue(extTimeValue),
        .start(start), .interval(interval), .tv(tv), .en(en), .count(count),
        .busy(busy), .expired(expired), .reprog_ack(reprog_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every expired pulse must match the oldest outstanding expected cycle.
    always @(negedge clk) begin
        if (expired) begin
            chk("busy_low_with_expired", busy, 0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_expired: got pulse at cycle %0d expected none", cyc);
            end else begin
                chk("expired_cycle", cyc, q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] iv, input int n);
        start    = 1'b1;
        interval = iv;
        q.push_back(cyc + 1 + 4 * n);
        step();
        start = 1'b0;
    endtask

    task automatic wait_expiry(input string name, input int bound, output int en_cnt);
        int k;
        en_cnt = 0;
        k = 0;
        while (q.size() != 0 && k < bound) begin
            if (en) en_cnt++;
            step();
            k++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no expired within %0d cycles expected one", name, bound);
            q.delete();
        end
    endtask

    task automatic idle_quiet(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk({name, "_busy"}, busy, 0);
        end
    endtask

    initial begin
        int enc;
        vecs[0] = '{1'b0, 2'd0, 4'd0,  2'd0, 4'd6,  1'b0};
        vecs[1] = '{1'b0, 2'd0, 4'd0,  2'd1, 4'd3,  1'b0};
        vecs[2] = '{1'b0, 2'd0, 4'd0,  2'd2, 4'd2,  1'b0};
        vecs[3] = '{1'b0, 2'd0, 4'd0,  2'd3, 4'd3,  1'b0};
        vecs[4] = '{1'b1, 2'd0, 4'd4,  2'd0, 4'd4,  1'b1};
        vecs[5] = '{1'b1, 2'd2, 4'd0,  2'd2, 4'd1,  1'b1};
        vecs[6] = '{1'b1, 2'd3, 4'd15, 2'd3, 4'd15, 1'b1};
        vecs[7] = '{1'b1, 2'd1, 4'd9,  2'd1, 4'd9,  1'b1};
        vecs[8] = '{1'b0, 2'd0, 4'd0,  2'd0, 4'd4,  1'b0};

        reset = 1'b1; reprogram = 1'b0; extTimeSelector = 2'd0; extTimeValue = 4'd0;
        start = 1'b0; interval = 2'd0;
        step(); step();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_en", en, 0);
        chk("rst_count", count, 0);
        chk("rst_expired", expired, 0);
        chk("rst_ack", reprog_ack, 0);
        chk("rst_tv0", tv, 6);
        interval = 2'd2;
        #1 chk("rst_tv2", tv, 2);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_busy", busy, 0);
            chk("idle_en", en, 0);
            chk("idle_expired", expired, 0);
        end

        // Basic countdown of the base interval.
        do_start(2'd0, 6);
        chk("run_busy", busy, 1);
        chk("run_count_init", count, 6);
        wait_expiry("base", 40, enc);
        chk("base_en_pulses", enc, 6);
        chk("base_count_end", count, 0);
        chk("base_busy_end", busy, 0);

        // Reprogram vectors.
        for (int i = 0; i < 9; i++) begin
            reprogram       = vecs[i].rp;
            extTimeSelector = vecs[i].sel;
            extTimeValue    = vecs[i].val;
            interval        = vecs[i].iv;
            step();
            reprogram = 1'b0;
            chk($sformatf("vec%0d_tv", i), tv, vecs[i].exp_tv);
            chk($sformatf("vec%0d_ack", i), reprog_ack, vecs[i].exp_ack);
        end
        do_start(2'd0, 4);
        wait_expiry("reprog_base", 30, enc);
        chk("reprog_base_en_pulses", enc, 4);

        // Reset restores the table; then restart aborts the first interval.
        reset = 1'b1; step(); reset = 1'b0;
        interval = 2'd0; #1 chk("defaults_tv0", tv, 6);
        interval = 2'd2; #1 chk("defaults_tv2", tv, 2);
        do_start(2'd2, 2);
        step(); step(); step(); step();
        q.delete();
        do_start(2'd1, 3);
        chk("restart_count", count, 3);
        wait_expiry("restart", 30, enc);
        chk("restart_en_pulses", enc, 3);

        // Reprogram while running aborts without expired.
        do_start(2'd0, 6);
        step(); step(); step();
        q.delete();
        reprogram = 1'b1; extTimeSelector = 2'd3; extTimeValue = 4'd3;
        step();
        reprogram = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_count", count, 0);
        chk("abort_ack", reprog_ack, 1);
        idle_quiet("abort", 30);

        // Reprogram and start together: write wins, stays idle.
        reprogram = 1'b1; extTimeSelector = 2'd1; extTimeValue = 4'd5;
        start = 1'b1; interval = 2'd1;
        step();
        reprogram = 1'b0; start = 1'b0;
        chk("collide_busy", busy, 0);
        chk("collide_tv1", tv, 5);
        chk("collide_ack", reprog_ack, 1);
        idle_quiet("collide", 10);

        // Start on the expiring edge wins.
        do_start(2'd2, 2);
        for (int i = 0; i < 7; i++) step();
        chk("preexp_count", count, 1);
        chk("preexp_en", en, 1);
        q.delete();
        do_start(2'd2, 2);
        chk("reexp_busy", busy, 1);
        chk("reexp_count", count, 2);
        chk("reexp_expired", expired, 0);
        wait_expiry("reexp", 20, enc);

        // Reset mid-countdown with count=3.
        do_start(2'd0, 6);
        for (int i = 0; i < 12; i++) step();
        chk("midrst_count_pre", count, 3);
        q.delete();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_count", count, 0);
        chk("midrst_busy", busy, 0);
        interval = 2'd1; #1 chk("midrst_tv1", tv, 3);
        idle_quiet("midrst", 30);

        chk("scoreboard_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/interval_timer_sequencer.md
Name: interval_timer_sequencer

Overview:
Programmable interval timer and timing-table controller for the traffic light datapath. It holds the four-entry interval table (base, extended, yellow, walk) and applies reprogram writes from the external selector/value inputs. It runs a single countdown with a start/expired handshake, driven by an internal 1-tick-per-CLK_DIV enable. The main light FSM issues start+interval and waits for expired. It also exposes tv/en/count for debug.

Parameters:
CLK_DIV, 4, clock cycles per timer tick (>=2); sim value, set to clock Hz for 1 s ticks on hardware
DEF_BASE, 6, reset value of entry 0 (base green)
DEF_EXT, 3, reset value of entry 1 (extended green)
DEF_YEL, 2, reset value of entry 2 (yellow)
DEF_WALK, 3, reset value of entry 3 (walk)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high
reprogram  input  1  write strobe for interval table
extTimeSelector  input  2  table entry to write (0 base, 1 ext, 2 yellow, 3 walk)
extTimeValue  input  4  value to write
start  input  1  one-cycle request to begin countdown
interval  input  2  table entry to count when start sampled
tv  output  4  combinational table[interval]
en  output  1  timer tick, high one cycle every CLK_DIV cycles while RUN
count  output  4  remaining ticks
busy  output  1  high in RUN
expired  output  1  registered one-cycle done pulse
reprog_ack  output  1  registered one-cycle pulse after a reprogram write

Behaviour:
- Reset (sync, highest priority): table <= {DEF_BASE, DEF_EXT, DEF_YEL, DEF_WALK}; state IDLE; div=0; count=0; en=0; busy=0; expired=0; reprog_ack=0. Reset mid-countdown aborts it with no expired pulse.
- States: IDLE, RUN. busy = (state==RUN).
- Divider: div held at 0 in IDLE. In RUN, div increments modulo CLK_DIV. en = RUN && div==CLK_DIV-1 (combinational).
- Reprogram (priority over start):
  - When reprogram=1 at an edge: table[extTimeSelector] <= extTimeValue, except value 0, which is stored as 1 (minimum interval is 1 tick).
  - reprog_ack=1 for the next cycle.
  - If RUN, the countdown aborts: state IDLE, div=0, count=0, no expired.
  - A start on the same edge is ignored.
- Start (reprogram=0):
  - Applies in IDLE or RUN: count <= table[interval], div <= 0, state RUN.
  - Start in RUN restarts the countdown with no expired for the abandoned interval.
- Tick: in RUN, on an edge with en=1:
  - If count==1: count<=0, state IDLE, expired<=1.
  - Otherwise count<=count-1.
- Start on the same edge a tick would expire: start wins, restart, expired stays 0.
- Latency: start sampled at edge E0 gives expired high during the cycle after edge E0+N*CLK_DIV, where N = table[interval]. busy is high from E0 until that edge. expired is never high two consecutive cycles unless re-started.
- expired defaults to 0 every cycle it is not set.
- Width: count is 4-bit, max 15. No wrap, because count never decrements below 1 in RUN.
- tv reflects writes the cycle after the write edge.

Test Plan:
- Reset then idle 20 cycles -> tv=6 for interval=0, 2 for interval=2. busy=0, en=0, expired=0 throughout.
- start=1, interval=0 (N=6), CLK_DIV=4 -> en pulses every 4th cycle. count 6→5→…→1. expired high exactly 1 cycle, starting 24 cycles after the start edge. busy low with it.
- reprogram=1, extTimeSelector=0, extTimeValue=4 -> reprog_ack next cycle, tv=4 (interval=0). A following start -> expired after 16 cycles. Write of value 0 to entry 2 -> tv=1.
- Restart: start interval=2 (N=2), then at cycle 5 start interval=1 (N=3) -> no expired at cycle 8. expired 12 cycles after the second start.
- Collisions: reprogram during RUN -> busy drops next cycle, no expired ever. Simultaneous reprogram+start -> write occurs, state IDLE. start on the expiring edge -> no expired, new countdown runs.
- reset=1 mid-countdown with count=3 -> next cycle count=0, busy=0, table back to defaults, no expired.
